// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and constants for the MIPS two-port Avalon-MM bus arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   port_t        : requester identity, used for the round-robin history bit
//   BUS_IDLE_ADDR : address driven on the bus while no port is granted
//   FETCH_BE      : lane mask driven for instruction fetches (always full word)
// -----------------------------------------------------------------------------
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   localparam logic [31:0] BUS_IDLE_ADDR = 32'h0000_0000;
   localparam logic [3:0]  FETCH_BE      = 4'hF;

endpackage

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Shares the CPU's single Avalon-MM master between the instruction-fetch port
// (i_*) and the load/store port (d_*). Grants are registered and round-robin;
// the granted port's command is forwarded combinationally to the bus. A
// watchdog counts stalled cycles of one granted transfer and raises a sticky
// bus_timeout flag without ever aborting the transfer.
//
// Ports:
//   clk, reset (async, active-low)
//   i_address/i_read            -> fetch command in
//   i_waitrequest/i_readdata    <- fetch response out
//   d_address/d_read/d_write/d_writedata/d_byteenable -> data command in
//   d_waitrequest/d_readdata    <- data response out
//   address/read/write/writedata/byteenable -> Avalon bus command out
//   waitrequest/readdata        <- Avalon bus response in (zero-latency read)
//   bus_timeout                 -> sticky watchdog flag
// -----------------------------------------------------------------------------
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        bus_timeout
);

   localparam int unsigned     CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   port_t            r_last;
   logic [CNT_W-1:0] r_wdog_cnt;
   logic [CNT_W-1:0] w_wdog_cnt_next;
   logic             r_bus_timeout;
   logic             w_i_req;
   logic             w_d_req;
   logic             w_complete;
   logic             w_grant_entry;
   logic             w_stall;

   assign w_i_req     = i_read;
   assign w_d_req     = d_read | d_write;
   assign bus_timeout = r_bus_timeout;

   // Next-state and completion decode; completion needs waitrequest, which
   // only feeds state/history registers, never the bus command outputs.
   always_comb begin
      w_next_state = r_state;
      w_complete   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               w_next_state = (r_last == PORT_D) ? GRANT_I : GRANT_D;
            end else if (w_i_req) begin
               w_next_state = GRANT_I;
            end else if (w_d_req) begin
               w_next_state = GRANT_D;
            end else begin
               w_next_state = IDLE;
            end
         end
         GRANT_I: begin
            if (!w_i_req) begin
               // Requester gave up without completing: history untouched.
               w_next_state = IDLE;
            end else if (!waitrequest) begin
               w_complete   = 1'b1;
               w_next_state = w_d_req ? GRANT_D : IDLE;
            end else begin
               w_next_state = GRANT_I;
            end
         end
         GRANT_D: begin
            if (!w_d_req) begin
               w_next_state = IDLE;
            end else if (!waitrequest) begin
               w_complete   = 1'b1;
               w_next_state = w_i_req ? GRANT_I : IDLE;
            end else begin
               w_next_state = GRANT_D;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Bus command and requester response muxing from the registered grant.
   always_comb begin
      address       = BUS_IDLE_ADDR;
      read          = 1'b0;
      write         = 1'b0;
      writedata     = 32'h0000_0000;
      byteenable    = 4'h0;
      i_waitrequest = 1'b1;
      i_readdata    = 32'h0000_0000;
      d_waitrequest = 1'b1;
      d_readdata    = 32'h0000_0000;
      case (r_state)
         GRANT_I: begin
            address       = i_address;
            read          = i_read;
            byteenable    = FETCH_BE;
            i_waitrequest = waitrequest;
            i_readdata    = readdata;
         end
         GRANT_D: begin
            // A simultaneous read and write is treated as a write.
            address       = d_address;
            read          = d_read & ~d_write;
            write         = d_write;
            writedata     = d_writedata;
            byteenable    = d_byteenable;
            d_waitrequest = waitrequest;
            d_readdata    = readdata;
         end
         default: begin
            address = BUS_IDLE_ADDR;
         end
      endcase
   end

   assign w_grant_entry = (w_next_state != IDLE) && (w_next_state != r_state);
   assign w_stall       = (r_state != IDLE) && waitrequest;

   // Watchdog counter next value: cleared on grant entry, saturating count.
   always_comb begin
      w_wdog_cnt_next = r_wdog_cnt;
      if (w_grant_entry) begin
         w_wdog_cnt_next = {CNT_W{1'b0}};
      end else if (w_stall && (r_wdog_cnt != TIMEOUT_VAL)) begin
         w_wdog_cnt_next = r_wdog_cnt + CNT_W'(1);
      end else begin
         w_wdog_cnt_next = r_wdog_cnt;
      end
   end

   // State, round-robin history and watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_last        <= PORT_D;
         r_wdog_cnt    <= {CNT_W{1'b0}};
         r_bus_timeout <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wdog_cnt <= w_wdog_cnt_next;
         if (w_complete) begin
            r_last <= (r_state == GRANT_I) ? PORT_I : PORT_D;
         end
         // Sticky: set on the edge where the count reaches the limit.
         if (w_wdog_cnt_next == TIMEOUT_VAL) begin
            r_bus_timeout <= 1'b1;
         end
      end
   end

endmodule
